// File: rtl/matrix_mem_loader.sv
// Host-side job writer: takes a header (R, K, C) plus A and B from a valid/ready
// stream and writes them, one word per cycle, into the shared main memory.
module matrix_mem_loader #(
    parameter int MAX_ROW_A  = 16,
    parameter int MAX_COMMON = 16,
    parameter int MAX_COL_B  = 16,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int BASE_ADDR  = 0,
    parameter int AUTO_START = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_write_readbar,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              getting_input,
    output logic              start_out,
    output logic              busy,
    output logic              load_done,
    output logic              error
);

    localparam int MAX_A = MAX_ROW_A * MAX_COMMON;
    localparam int MAX_B = MAX_COMMON * MAX_COL_B;
    localparam int MAX_N = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_N + 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [63:0] MEM_WORDS = 64'd1 << ADDR_W;

    typedef enum logic [3:0] {
        IDLE,
        HDR_R,
        HDR_K,
        HDR_C,
        CHECK,
        LOAD_A,
        LOAD_B,
        FLUSH,
        DONE,
        ERR
    } state_t;

    state_t state_reg, state_next;

    logic [DATA_W-1:0] r_reg, k_reg, c_reg;
    logic [CNT_W-1:0]  na_reg, nb_reg, cnt_reg;
    logic [ADDR_W-1:0] wr_addr_reg;

    logic        accept;
    logic        last_a, last_b;
    logic        hdr_bad;
    logic [31:0] r32, k32, c32;
    logic [31:0] prod_rk, prod_kc;
    logic [63:0] total_words;

    assign accept = in_valid & in_ready;

    // Header products are formed at 32 bits; the footprint sum is widened so it
    // cannot wrap when compared against the memory size.
    assign r32         = 32'(r_reg);
    assign k32         = 32'(k_reg);
    assign c32         = 32'(c_reg);
    assign prod_rk     = r32 * k32;
    assign prod_kc     = k32 * c32;
    assign total_words = 64'(BASE_ADDR) + 64'd3 + 64'(prod_rk) + 64'(prod_kc);

    always_comb begin
        hdr_bad = 1'b0;
        if (r32 == 32'd0 || k32 == 32'd0 || c32 == 32'd0)
            hdr_bad = 1'b1;
        if (r32 > 32'(MAX_ROW_A) || k32 > 32'(MAX_COMMON) || c32 > 32'(MAX_COL_B))
            hdr_bad = 1'b1;
        if (total_words > MEM_WORDS)
            hdr_bad = 1'b1;
    end

    // Final-element compares use the counts latched in CHECK.
    assign last_a = (cnt_reg == (na_reg - CNT_W'(1)));
    assign last_b = (cnt_reg == (nb_reg - CNT_W'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        in_ready      = 1'b0;
        busy          = 1'b0;
        getting_input = 1'b0;
        start_out     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load_req)
                    state_next = HDR_R;
            end
            HDR_R: begin
                in_ready = 1'b1;
                if (accept)
                    state_next = HDR_K;
            end
            HDR_K: begin
                in_ready = 1'b1;
                if (accept)
                    state_next = HDR_C;
            end
            HDR_C: begin
                in_ready = 1'b1;
                if (accept)
                    state_next = CHECK;
            end
            CHECK: begin
                state_next = hdr_bad ? ERR : LOAD_A;
            end
            LOAD_A: begin
                in_ready = 1'b1;
                if (accept && last_a)
                    state_next = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (accept && last_b)
                    state_next = FLUSH;
            end
            // FLUSH is the cycle the final element write is on the bus.
            FLUSH: begin
                state_next = DONE;
            end
            DONE: begin
                start_out  = (AUTO_START != 0);
                state_next = IDLE;
            end
            ERR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy          = (state_reg != IDLE) && (state_reg != DONE) && (state_reg != ERR);
        getting_input = busy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_write_readbar <= 1'b0;
            mem_addr          <= '0;
            mem_data          <= '0;
            wr_addr_reg       <= '0;
            r_reg             <= '0;
            k_reg             <= '0;
            c_reg             <= '0;
            na_reg            <= '0;
            nb_reg            <= '0;
            cnt_reg           <= '0;
            load_done         <= 1'b0;
            error             <= 1'b0;
        end else begin
            mem_write_readbar <= accept;
            if (accept) begin
                mem_data    <= in_data;
                mem_addr    <= wr_addr_reg;
                wr_addr_reg <= wr_addr_reg + ADDR_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (load_req) begin
                        wr_addr_reg <= BASE;
                        load_done   <= 1'b0;
                        error       <= 1'b0;
                        cnt_reg     <= '0;
                    end
                end
                HDR_R: if (accept) r_reg <= in_data;
                HDR_K: if (accept) k_reg <= in_data;
                HDR_C: if (accept) c_reg <= in_data;
                CHECK: begin
                    na_reg  <= CNT_W'(prod_rk);
                    nb_reg  <= CNT_W'(prod_kc);
                    cnt_reg <= '0;
                    if (hdr_bad)
                        error <= 1'b1;
                end
                LOAD_A: begin
                    if (accept)
                        cnt_reg <= last_a ? '0 : cnt_reg + CNT_W'(1);
                end
                LOAD_B: begin
                    if (accept)
                        cnt_reg <= last_b ? '0 : cnt_reg + CNT_W'(1);
                end
                FLUSH: load_done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mem_loader.sv
// Directed bench for matrix_mem_loader: a negedge monitor logs writes, accepts
// and start pulses; each scenario task checks its own slice of those logs.
module tb_matrix_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_req;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_write_readbar;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        getting_input;
    logic        start_out;
    logic        busy;
    logic        load_done;
    logic        error;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int gi_bad = 0;

    logic [9:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          acc_cyc_q[$];
    int          start_q[$];
    logic [31:0] tx_q[$];

    matrix_mem_loader dut (
        .clk              (clk),
        .reset            (reset),
        .load_req         (load_req),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .mem_write_readbar(mem_write_readbar),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .getting_input    (getting_input),
        .start_out        (start_out),
        .busy             (busy),
        .load_done        (load_done),
        .error            (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (in_valid && in_ready)
                acc_cyc_q.push_back(cyc);
            if (mem_write_readbar) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_data);
                wr_cyc_q.push_back(cyc);
                if (!getting_input)
                    gi_bad <= gi_bad + 1;
            end
            if (start_out) begin
                start_q.push_back(cyc);
                if (getting_input)
                    gi_bad <= gi_bad + 1;
            end
        end
    end

    task automatic start_job;
        @(posedge clk); #1;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic drive_stream(input int gap_pct, output int ok);
        int  n;
        logic acc;
        ok = 1;
        for (int i = 0; i < tx_q.size(); i++) begin
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 100) begin
                @(posedge clk); #1;
                if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                    in_valid = 1'b0;
                    in_data  = 32'hDEAD_BEEF;
                end else begin
                    in_valid = 1'b1;
                    in_data  = tx_q[i];
                end
                @(negedge clk);
                acc = in_valid && in_ready;
                n++;
            end
            if (!acc) ok = 0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 32'h0;
    endtask

    // Returns at the negedge of the first cycle with load_done or error high.
    task automatic wait_end(output int ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!load_done && !error && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (load_done || error) ? 1 : 0;
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_write_readbar, in_ready, busy, getting_input, start_out, load_done, error} !== 7'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {mem_write_readbar, in_ready, busy, getting_input, start_out, load_done, error});
        end
        checks++;
        if (mem_addr !== 10'd0 || mem_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_mem: addr %0d data %0h expected 0 0", mem_addr, mem_data);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy %b in_ready %b expected 0 0", busy, in_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic;
        int bw, ba, bs, bg, ok, ok2;
        bw = wr_addr_q.size(); ba = acc_cyc_q.size(); bs = start_q.size(); bg = gi_bad;
        tx_q = '{32'd2, 32'd2, 32'd2, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        start_job();
        checks++;
        if (getting_input !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_hdr_entry: getting_input %b busy %b expected 1 1", getting_input, busy);
        end
        drive_stream(0, ok);
        wait_end(ok2);
        checks++;
        if (ok !== 1 || ok2 !== 1) begin
            fails++;
            $display("FAIL basic_timeout: stream %0d end %0d expected 1 1", ok, ok2);
        end
        checks++;
        if (start_out !== 1'b1 || getting_input !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_cycle: start_out %b getting_input %b expected 1 0", start_out, getting_input);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wr_addr_q.size() - bw !== 11) begin
            fails++;
            $display("FAIL basic_write_count: got %0d expected 11", wr_addr_q.size() - bw);
        end else begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (wr_addr_q[bw+i] !== 10'(i) || wr_data_q[bw+i] !== tx_q[i]) begin
                    fails++;
                    $display("FAIL basic_write[%0d]: addr %0d data %0d expected %0d %0d",
                             i, wr_addr_q[bw+i], wr_data_q[bw+i], i, tx_q[i]);
                end
                checks++;
                if (wr_cyc_q[bw+i] !== acc_cyc_q[ba+i] + 1) begin
                    fails++;
                    $display("FAIL basic_latency[%0d]: write cycle %0d expected %0d",
                             i, wr_cyc_q[bw+i], acc_cyc_q[ba+i] + 1);
                end
            end
            checks++;
            if (wr_cyc_q[bw+10] - wr_cyc_q[bw+3] !== 7) begin
                fails++;
                $display("FAIL basic_element_b2b: span %0d expected 7", wr_cyc_q[bw+10] - wr_cyc_q[bw+3]);
            end
            checks++;
            if (start_q.size() - bs !== 1) begin
                fails++;
                $display("FAIL basic_start_count: got %0d expected 1", start_q.size() - bs);
            end else begin
                checks++;
                if (start_q[bs] !== wr_cyc_q[bw+10] + 1) begin
                    fails++;
                    $display("FAIL basic_start_time: cycle %0d expected %0d", start_q[bs], wr_cyc_q[bw+10] + 1);
                end
            end
        end
        checks++;
        if (gi_bad - bg !== 0) begin
            fails++;
            $display("FAIL basic_getting_input: bad cycles %0d expected 0", gi_bad - bg);
        end
        checks++;
        if (load_done !== 1'b1 || error !== 1'b0 || start_out !== 1'b0) begin
            fails++;
            $display("FAIL basic_flags: load_done %b error %b start_out %b expected 1 0 0", load_done, error, start_out);
        end
        $display("test_basic 2x2x2 done, %0d writes", wr_addr_q.size() - bw);
    endtask

    task automatic test_hdr_zero;
        int bw, bs, ok, ok2;
        bw = wr_addr_q.size(); bs = start_q.size();
        tx_q = '{32'd0, 32'd4, 32'd4};
        start_job();
        checks++;
        if (load_done !== 1'b0) begin
            fails++;
            $display("FAIL zero_clear_done: load_done %b expected 0", load_done);
        end
        drive_stream(0, ok);
        wait_end(ok2);
        checks++;
        if (error !== 1'b1 || load_done !== 1'b0 || in_ready !== 1'b0 || ok !== 1 || ok2 !== 1) begin
            fails++;
            $display("FAIL zero_err_state: error %b load_done %b in_ready %b stream %0d end %0d expected 1 0 0 1 1",
                     error, load_done, in_ready, ok, ok2);
        end
        // Keep offering words after the rejection; none may be taken.
        in_valid = 1'b1;
        in_data  = 32'h55;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL zero_in_ready: got %b expected 0", in_ready);
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wr_addr_q.size() - bw !== 3) begin
            fails++;
            $display("FAIL zero_write_count: got %0d expected 3", wr_addr_q.size() - bw);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr_q[bw+i] !== 10'(i) || wr_data_q[bw+i] !== tx_q[i]) begin
                    fails++;
                    $display("FAIL zero_hdr_write[%0d]: addr %0d data %0d expected %0d %0d",
                             i, wr_addr_q[bw+i], wr_data_q[bw+i], i, tx_q[i]);
                end
            end
        end
        checks++;
        if (start_q.size() - bs !== 0 || error !== 1'b1) begin
            fails++;
            $display("FAIL zero_no_start: starts %0d error %b expected 0 1", start_q.size() - bs, error);
        end
        $display("test_hdr_zero done, %0d writes", wr_addr_q.size() - bw);
    endtask

    task automatic test_hdr_range;
        int bw, bs, ok, ok2, bad;
        bw = wr_addr_q.size(); bs = start_q.size();
        tx_q = '{32'd17, 32'd1, 32'd1};
        start_job();
        checks++;
        if (error !== 1'b0) begin
            fails++;
            $display("FAIL range_clear_error: error %b expected 0", error);
        end
        drive_stream(0, ok);
        wait_end(ok2);
        checks++;
        if (error !== 1'b1 || load_done !== 1'b0) begin
            fails++;
            $display("FAIL range_r17: error %b load_done %b expected 1 0", error, load_done);
        end
        repeat (2) @(posedge clk);
        bw = wr_addr_q.size();
        tx_q = '{32'd16, 32'd16, 32'd16};
        for (int i = 0; i < 512; i++) tx_q.push_back(32'd1000 + 32'(i));
        start_job();
        drive_stream(0, ok);
        wait_end(ok2);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (load_done !== 1'b1 || error !== 1'b0 || ok !== 1 || ok2 !== 1) begin
            fails++;
            $display("FAIL range_16_flags: load_done %b error %b stream %0d end %0d expected 1 0 1 1",
                     load_done, error, ok, ok2);
        end
        checks++;
        if (wr_addr_q.size() - bw !== 515) begin
            fails++;
            $display("FAIL range_16_count: got %0d expected 515", wr_addr_q.size() - bw);
        end else begin
            bad = 0;
            for (int i = 0; i < 515; i++) begin
                checks++;
                if (wr_addr_q[bw+i] !== 10'(i) || wr_data_q[bw+i] !== tx_q[i]) begin
                    fails++;
                    if (bad < 4)
                        $display("FAIL range_16_write[%0d]: addr %0d data %0d expected %0d %0d",
                                 i, wr_addr_q[bw+i], wr_data_q[bw+i], i, tx_q[i]);
                    bad++;
                end
            end
        end
        checks++;
        if (start_q.size() - bs !== 1) begin
            fails++;
            $display("FAIL range_16_start: got %0d expected 1", start_q.size() - bs);
        end
        $display("test_hdr_range done, 16x16x16 wrote %0d words", wr_addr_q.size() - bw);
    endtask

    task automatic test_gaps;
        int bw, ba, ok, ok2;
        bw = wr_addr_q.size(); ba = acc_cyc_q.size();
        tx_q = '{32'd3, 32'd1, 32'd2, 32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1};
        start_job();
        drive_stream(40, ok);
        wait_end(ok2);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wr_addr_q.size() - bw !== 8 || acc_cyc_q.size() - ba !== 8 || ok !== 1 || ok2 !== 1) begin
            fails++;
            $display("FAIL gaps_count: writes %0d accepts %0d stream %0d end %0d expected 8 8 1 1",
                     wr_addr_q.size() - bw, acc_cyc_q.size() - ba, ok, ok2);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wr_addr_q[bw+i] !== 10'(i) || wr_data_q[bw+i] !== tx_q[i]) begin
                    fails++;
                    $display("FAIL gaps_write[%0d]: addr %0d data %0h expected %0d %0h",
                             i, wr_addr_q[bw+i], wr_data_q[bw+i], i, tx_q[i]);
                end
                checks++;
                if (wr_cyc_q[bw+i] !== acc_cyc_q[ba+i] + 1) begin
                    fails++;
                    $display("FAIL gaps_timing[%0d]: write cycle %0d expected %0d",
                             i, wr_cyc_q[bw+i], acc_cyc_q[ba+i] + 1);
                end
            end
        end
        checks++;
        if (load_done !== 1'b1 || error !== 1'b0) begin
            fails++;
            $display("FAIL gaps_flags: load_done %b error %b expected 1 0", load_done, error);
        end
        $display("test_gaps 3x1x2 done, %0d writes", wr_addr_q.size() - bw);
    endtask

    task automatic test_reset_mid;
        int bw, bs, ok, ok2;
        bs = start_q.size();
        tx_q = '{32'd4, 32'd4, 32'd4, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
        start_job();
        drive_stream(0, ok);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_write_readbar, in_ready, busy, getting_input, start_out, load_done, error} !== 7'b0
            || mem_addr !== 10'd0 || mem_data !== 32'd0) begin
            fails++;
            $display("FAIL midreset_outputs: flags %b addr %0d data %0d expected 0000000 0 0",
                     {mem_write_readbar, in_ready, busy, getting_input, start_out, load_done, error},
                     mem_addr, mem_data);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (start_q.size() - bs !== 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_no_start: starts %0d busy %b expected 0 0", start_q.size() - bs, busy);
        end
        bw = wr_addr_q.size();
        tx_q = '{32'd1, 32'd1, 32'd1, 32'd9, 32'd8};
        start_job();
        drive_stream(0, ok);
        wait_end(ok2);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wr_addr_q.size() - bw !== 5) begin
            fails++;
            $display("FAIL midreset_restart_count: got %0d expected 5", wr_addr_q.size() - bw);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wr_addr_q[bw+i] !== 10'(i) || wr_data_q[bw+i] !== tx_q[i]) begin
                    fails++;
                    $display("FAIL midreset_restart[%0d]: addr %0d data %0d expected %0d %0d",
                             i, wr_addr_q[bw+i], wr_data_q[bw+i], i, tx_q[i]);
                end
            end
        end
        checks++;
        if (load_done !== 1'b1 || start_q.size() - bs !== 1 || ok !== 1 || ok2 !== 1) begin
            fails++;
            $display("FAIL midreset_restart_done: load_done %b starts %0d stream %0d end %0d expected 1 1 1 1",
                     load_done, start_q.size() - bs, ok, ok2);
        end
        $display("test_reset_mid done, restart wrote %0d words", wr_addr_q.size() - bw);
    endtask

    task automatic test_load_req_ignored;
        int bw, bs, ok, ok2;
        bw = wr_addr_q.size(); bs = start_q.size();
        tx_q = '{32'd2, 32'd2, 32'd2, 32'd21, 32'd22, 32'd23, 32'd24, 32'd31, 32'd32, 32'd33, 32'd34};
        start_job();
        ok = 0;
        fork
            drive_stream(0, ok);
            begin
                repeat (6) @(posedge clk);
                #1;
                load_req = 1'b1;
                @(posedge clk); #1;
                load_req = 1'b0;
            end
        join
        wait_end(ok2);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wr_addr_q.size() - bw !== 11) begin
            fails++;
            $display("FAIL ignore_write_count: got %0d expected 11", wr_addr_q.size() - bw);
        end else begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (wr_addr_q[bw+i] !== 10'(i) || wr_data_q[bw+i] !== tx_q[i]) begin
                    fails++;
                    $display("FAIL ignore_write[%0d]: addr %0d data %0d expected %0d %0d",
                             i, wr_addr_q[bw+i], wr_data_q[bw+i], i, tx_q[i]);
                end
            end
        end
        checks++;
        if (load_done !== 1'b1 || error !== 1'b0 || start_q.size() - bs !== 1 || ok !== 1 || ok2 !== 1) begin
            fails++;
            $display("FAIL ignore_done: load_done %b error %b starts %0d stream %0d end %0d expected 1 0 1 1 1",
                     load_done, error, start_q.size() - bs, ok, ok2);
        end
        start_job();
        checks++;
        if (load_done !== 1'b0 || error !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL ignore_idle_req: load_done %b error %b busy %b in_ready %b expected 0 0 1 1",
                     load_done, error, busy, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        $display("test_load_req_ignored done, %0d writes", wr_addr_q.size() - bw);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hdr_zero();
        test_hdr_range();
        test_gaps();
        test_reset_mid();
        test_load_req_ignored();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
